// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the processor (master) and dmem_responder (slave).
// req_signed exists only when DMEM_LOAD_SIGNEXT_EN is defined.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_LOAD_SIGNEXT_EN
    logic        req_signed;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
`ifdef DMEM_LOAD_SIGNEXT_EN
        output req_signed,
`endif
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
`ifdef DMEM_LOAD_SIGNEXT_EN
        input  req_signed,
`endif
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Slow big-endian byte-addressed data memory: one request at a time, WAIT_CYCLES extra cycles,
// then a held response. Async active-high reset. Optional macro DMEM_LOAD_SIGNEXT_EN adds signed sub-word loads.
module dmem_responder #(
    parameter int DEPTH_BYTES = 32,
    parameter int AW          = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [3:0]    WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [AW-1:0] IDX_ONE   = AW'(32'd1);
    localparam logic [AW-1:0] IDX_TWO   = AW'(32'd2);
    localparam logic [AW-1:0] IDX_THREE = AW'(32'd3);

    // Misaligned half/word or reserved size is an error; bytes are always legal.
    function automatic logic req_err_f(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Big-endian assembly: b0 is the byte at the request address.
    function automatic logic [31:0] load_f(input logic [1:0] size, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3, input logic sext);
        case (size)
            2'b00:   return {{24{sext & b0[7]}}, b0};
            2'b01:   return {{16{sext & b0[7]}}, b0, b1};
            2'b10:   return {b0, b1, b2, b3};
            default: return 32'h0000_0000;
        endcase
    endfunction

    logic [7:0]    mem_r [DEPTH_BYTES];
    state_t        state_r;
    logic [3:0]    cnt_r;
    logic          we_r;
    logic [1:0]    size_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic          req_ready_r;
    logic          rsp_valid_r;
    logic [31:0]   rsp_rdata_r;
    logic          rsp_err_r;
    logic          busy_r;

    logic [AW-1:0] idx1_s, idx2_s, idx3_s;
    logic          err_s;
    logic          access_s;
    logic          sext_s;
    logic [31:0]   rdata_s;

`ifdef DMEM_LOAD_SIGNEXT_EN
    logic          signed_r;

    // Capture the signedness flag with the rest of the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signed_r <= 1'b0;
        end else if (state_r == ST_IDLE && bus.req_valid && req_ready_r) begin
            signed_r <= bus.req_signed;
        end
    end

    assign sext_s = signed_r;
`else
    assign sext_s = 1'b0;
`endif

    assign idx1_s   = addr_r + IDX_ONE;
    assign idx2_s   = addr_r + IDX_TWO;
    assign idx3_s   = addr_r + IDX_THREE;
    assign err_s    = req_err_f(size_r, addr_r[1:0]);
    assign access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);

    // Load data for the access edge; stores and errors return zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (we_r || err_s) begin
            rdata_s = 32'h0000_0000;
        end else begin
            rdata_s = load_f(size_r, mem_r[addr_r], mem_r[idx1_s], mem_r[idx2_s],
                             mem_r[idx3_s], sext_s);
        end
    end

    // Request/response sequencing with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        we_r        <= bus.req_we;
                        size_r      <= bus.req_size;
                        addr_r      <= bus.req_addr[AW-1:0];
                        wdata_r     <= bus.req_wdata;
                        cnt_r       <= WAIT_INIT;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_rdata_r <= rdata_s;
                        rsp_err_r   <= err_s;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Array write on the access edge; the array has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (access_s && we_r && !err_s) begin
            case (size_r)
                2'b00: begin
                    mem_r[addr_r] <= wdata_r[7:0];
                end
                2'b01: begin
                    mem_r[addr_r] <= wdata_r[15:8];
                    mem_r[idx1_s] <= wdata_r[7:0];
                end
                2'b10: begin
                    mem_r[addr_r] <= wdata_r[31:24];
                    mem_r[idx1_s] <= wdata_r[23:16];
                    mem_r[idx2_s] <= wdata_r[15:8];
                    mem_r[idx3_s] <= wdata_r[7:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (slave) for the processor's load/store port: accepts one request at a time, waits a programmable number of cycles, performs the access, then returns a response.
- Byte-addressed, big-endian, 32-byte array, matching the processor's data-memory layout (byte at addr holds word bits 31:24).
- Replaces the processor's zero-latency inline data memory when modelling a slow memory.

Parameters:
- DEPTH_BYTES, 32, number of bytes in the array (power of 2).
- AW, 5, array index width, log2(DEPTH_BYTES).
- WAIT_CYCLES, 2, extra wait cycles before the access (0..15).

Ports:
- clk  input  1  clock, all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_addr  input  32  byte address; only [AW-1:0] used, so it wraps modulo DEPTH_BYTES.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load data, right-aligned and zero-extended; 0 for stores and errors.
- rsp_err  output  1  misaligned or reserved-size request.
- busy  output  1  high in WAIT or RESP.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter 0.
- Reset never clears the memory array.
- State IDLE:
  - A handshake occurs when req_valid & req_ready.
  - On handshake: capture we, size, addr[AW-1:0] and wdata; load counter with WAIT_CYCLES; go to WAIT.
- State WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access at this edge, register rsp_rdata and rsp_err, and go to RESP.
- State RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_valid & rsp_ready, go to IDLE at that edge.
  - A new request cannot be accepted in the same cycle (req_ready=0 in RESP).
- Latency: with acceptance at edge N, rsp_valid rises after edge N+WAIT_CYCLES+1.
- Error cases:
  - Half access with addr[0]=1 sets rsp_err=1.
  - Word access with addr[1:0]!=0 sets rsp_err=1.
  - size=11 sets rsp_err=1.
  - On any error: no array write and rsp_rdata=0.
- Store:
  - Word: a..a+3 receive wdata[31:24], [23:16], [15:8], [7:0].
  - Half: a receives [15:8], a+1 receives [7:0].
  - Byte: a receives [7:0].
- Load: bytes are assembled in the same big-endian order, right-aligned, with the upper bits zero.
- Address wrap: the index is addr[AW-1:0]. An aligned access never crosses the top of the array, so no intra-access wrap occurs.
- Stores respond with rsp_rdata=0 and rsp_err=0.
- Inputs are ignored outside an IDLE handshake: changes to req_* during WAIT/RESP have no effect.
- Reset asserted mid-operation: returns to IDLE immediately and the pending request is dropped. A store is not written unless its access edge already occurred.
- Reset asserted in the same cycle as an access edge: reset wins.
- rsp_ready held high in advance: the response completes one cycle after rsp_valid rises.

Optional Feature:
- Macro DMEM_LOAD_SIGNEXT_EN.
- When defined:
  - Adds input port req_signed (1 bit), captured at the handshake.
  - Byte and half loads with req_signed=1 sign-extend into rsp_rdata[31:8] or [31:16].
- When undefined: the port is absent and all loads zero-extend.
- Word loads, stores and error responses are unaffected either way.

Test Plan:
- Word store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to addr 8.
  - Required: bytes 8..11 = DE AD BE EF; load returns 0xDEADBEEF with rsp_valid rising 3 edges after acceptance.
- Byte and half loads:
  - Array bytes 4..7 = 81 22 33 44.
  - Byte load at 4 returns 0x00000081 (0xFFFFFF81 with DMEM_LOAD_SIGNEXT_EN and req_signed=1).
  - Half load at 6 returns 0x00003344.
- Misalignment:
  - Word store to addr 6 with wdata 0x11111111: rsp_err=1, rsp_rdata=0, bytes 6..9 unchanged.
  - Half load at addr 3: rsp_err=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Required: rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; an incoming req_valid is not accepted until the cycle after the response handshake.
- Wrap and WAIT_CYCLES=0:
  - Store byte 0x5A to addr 0x21: lands at index 1; load at addr 1 returns 0x0000005A.
  - Required: rsp_valid rises 1 edge after acceptance.
- Reset mid-WAIT:
  - Assert reset one cycle after accepting a word store of 0xCAFEBABE to addr 12.
  - Required: bytes 12..15 unchanged, rsp_valid=0, req_ready=1 immediately, earlier array contents intact.
